// File: rtl/bcd_cevirici_if.sv
// bcd_cevirici_if: start/busy/done handshake and data bus of the binary-to-BCD converter.
//   basla  : start request (master -> slave)
//   sayi   : binary operand (master -> slave)
//   bcd    : packed BCD result, digit 0 in [3:0] (slave -> master)
//   isaret : sign of the last result (slave -> master)
//   mesgul : conversion in progress (slave -> master)
//   hazir  : one-cycle pulse when bcd/isaret update (slave -> master)
interface bcd_cevirici_if #(
  parameter int unsigned GENISLIK = 64,
  parameter int unsigned BASAMAK  = 20
);
  logic                   basla;
  logic [GENISLIK-1:0]    sayi;
  logic [4*BASAMAK-1:0]   bcd;
  logic                   isaret;
  logic                   mesgul;
  logic                   hazir;

  modport master (output basla, sayi, input bcd, isaret, mesgul, hazir);
  modport slave  (input basla, sayi, output bcd, isaret, mesgul, hazir);
endinterface

// File: rtl/bcd_cevirici.sv
// bcd_cevirici: sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Takes the 64-bit multiplier product and produces 20 packed BCD digits for the display.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   s   : bcd_cevirici_if.slave (basla, sayi in; bcd, isaret, mesgul, hazir out)
// Optional feature: define BCD_ISARET_EN to treat sayi as two's complement; the magnitude
// is converted and the sign is reported on isaret. Without it, isaret is tied to 0.
module bcd_cevirici #(
  parameter int unsigned GENISLIK = 64,
  parameter int unsigned BASAMAK  = 20
) (
  input  logic           clk,
  input  logic           rst,
  bcd_cevirici_if.slave  s
);

  localparam int unsigned BW = 4 * BASAMAK;
  localparam int unsigned SW = BW + GENISLIK;
  localparam int unsigned CW = $clog2(GENISLIK);

  typedef enum logic [1:0] {BOS, CEVIR, BITTI} durum_t;

  durum_t              durum;
  logic [SW-1:0]       sr;
  logic [SW-1:0]       sr_kay;
  logic [CW-1:0]       sayac;
  logic [BW-1:0]       bcd_q;
  logic                mesgul_q;
  logic                hazir_q;
  logic [GENISLIK-1:0] yuk;
  logic                yuk_isaret;

`ifdef BCD_ISARET_EN
  logic isaret_q;
  logic isaret_bek;

  // Negative operands are converted as their unsigned magnitude; -2^63 maps to itself.
  assign yuk_isaret = s.sayi[GENISLIK-1];
  assign yuk        = yuk_isaret ? GENISLIK'(~s.sayi + GENISLIK'(1)) : s.sayi;
  assign s.isaret   = isaret_q;
`else
  assign yuk_isaret = 1'b0;
  assign yuk        = s.sayi;
  assign s.isaret   = 1'b0;
`endif

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register.
  always_comb begin
    logic [SW-1:0] t;
    logic [3:0]    nib;
    t   = sr;
    nib = 4'd0;
    for (int i = 0; i < int'(BASAMAK); i++) begin
      nib = sr[GENISLIK + 4*i +: 4];
      if (nib >= 4'd5) t[GENISLIK + 4*i +: 4] = nib + 4'd3;
    end
    sr_kay = t << 1;
  end

  // Control FSM with registered outputs; bcd/isaret only move on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum    <= BOS;
      sr       <= '0;
      sayac    <= '0;
      bcd_q    <= '0;
      mesgul_q <= 1'b0;
      hazir_q  <= 1'b0;
`ifdef BCD_ISARET_EN
      isaret_q   <= 1'b0;
      isaret_bek <= 1'b0;
`endif
    end else begin
      case (durum)
        BOS, BITTI: begin
          hazir_q <= 1'b0;
          if (s.basla) begin
            sr       <= {BW'(0), yuk};
            sayac    <= '0;
            mesgul_q <= 1'b1;
            durum    <= CEVIR;
`ifdef BCD_ISARET_EN
            isaret_bek <= yuk_isaret;
`endif
          end else begin
            durum <= BOS;
          end
        end
        CEVIR: begin
          sr    <= sr_kay;
          sayac <= sayac + CW'(1);
          if (sayac == CW'(GENISLIK - 1)) begin
            bcd_q    <= sr_kay[SW-1 -: BW];
            hazir_q  <= 1'b1;
            mesgul_q <= 1'b0;
            durum    <= BITTI;
`ifdef BCD_ISARET_EN
            isaret_q <= isaret_bek;
`endif
          end
        end
        default: durum <= BOS;
      endcase
    end
  end

  assign s.bcd    = bcd_q;
  assign s.mesgul = mesgul_q;
  assign s.hazir  = hazir_q;

`ifndef BCD_ISARET_EN
  // The sign bit only matters in the signed build.
  logic unused_isaret;
  assign unused_isaret = yuk_isaret;
`endif

endmodule

// File: tb/tb_bcd_cevirici.sv
// tb_bcd_cevirici: scoreboard bench for bcd_cevirici with a decimal reference model.
module tb_bcd_cevirici;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pcyc;

  bcd_cevirici_if bif ();

  bcd_cevirici dut (
    .clk (clk),
    .rst (rst),
    .s   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct {
    logic [79:0] bcd;
    logic        sign;
    int          drv;
  } exp_t;

  exp_t        q[$];
  logic [79:0] last_bcd;
  logic        last_sgn;

  // Reference: decimal digits by repeated division of the magnitude.
  function automatic logic [79:0] ref_bcd(input logic [63:0] v);
    logic [79:0] r;
    logic [63:0] m;
    r = '0;
    m = v;
`ifdef BCD_ISARET_EN
    if (v[63]) m = 64'(0) - v;
`endif
    for (int i = 0; i < 20; i++) begin
      r[4*i +: 4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
    return r;
  endfunction

  function automatic logic ref_sign(input logic [63:0] v);
`ifdef BCD_ISARET_EN
    return v[63];
`else
    return 1'b0 & v[0];
`endif
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v >> $urandom_range(0, 63);
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] v, input int drv);
    exp_t e;
    e.bcd  = ref_bcd(v);
    e.sign = ref_sign(v);
    e.drv  = drv;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation on every hazir pulse; also checks pulse and busy widths.
  int   run;
  logic prev_h;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run    = 0;
      prev_h = 1'b0;
    end else begin
      if (bif.mesgul) run++;
      else if (run != 0) begin
        chk("mesgul_width", 80'(run), 80'(64));
        run = 0;
      end
      if (bif.hazir) begin
        chk("hazir_width", 80'(prev_h), 80'(0));
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_hazir: got bcd %h with no pending request", bif.bcd);
        end else begin
          e = q.pop_front();
          chk("bcd", bif.bcd, e.bcd);
          chk("isaret", 80'(bif.isaret), 80'(e.sign));
          chk("latency", 80'(pcyc - e.drv), 80'(65));
          last_bcd = e.bcd;
          last_sgn = e.sign;
        end
      end
      prev_h = bif.hazir;
    end
  end

  task automatic convert(input logic [63:0] v);
    @(negedge clk);
    bif.basla = 1'b1;
    bif.sayi  = v;
    push(v, pcyc);
    @(negedge clk);
    bif.basla = 1'b0;
    bif.sayi  = rnd64();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || bif.mesgul || bif.hazir) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL idle_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  // basla held high: accepts at base+1, base+66, ...; sayi changes right after each accept.
  task automatic hold_run(input int n);
    int          base;
    logic [63:0] v;
    @(negedge clk);
    base = pcyc;
    for (int j = 0; j < n; j++) begin
      if (j > 0) while (pcyc != base + 1 + 65*(j-1)) @(negedge clk);
      v = rnd64();
      bif.sayi  = v;
      bif.basla = 1'b1;
      push(v, base + 65*j);
    end
    while (pcyc != base + 1 + 65*(n-1)) @(negedge clk);
    bif.basla = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    pcyc      = 0;
    last_bcd  = '0;
    last_sgn  = 1'b0;
    rst       = 1'b1;
    bif.basla = 1'b0;
    bif.sayi  = '0;
    #1;
    chk("reset_bcd", bif.bcd, 80'h0);
    chk("reset_flags", 80'({bif.isaret, bif.mesgul, bif.hazir}), 80'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    convert(64'd0);
    wait_idle();
    convert(64'd255);
    wait_idle();
    convert(64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    convert(64'h8000_0000_0000_0000);
    wait_idle();

    // Requests during a conversion are dropped; outputs hold the previous result.
    convert(64'd12345);
    repeat (8) @(negedge clk);
    bif.basla = 1'b1;
    bif.sayi  = 64'd99;
    @(negedge clk);
    bif.basla = 1'b0;
    chk("hold_bcd_c10", bif.bcd, last_bcd);
    chk("busy_c10", 80'(bif.mesgul), 80'(1));
    repeat (29) @(negedge clk);
    bif.basla = 1'b1;
    @(negedge clk);
    bif.basla = 1'b0;
    chk("hold_bcd_c40", bif.bcd, last_bcd);
    chk("hold_isaret_c40", 80'(bif.isaret), 80'(last_sgn));
    wait_idle();

    // Reset mid-conversion: outputs clear at once and no result appears.
    @(negedge clk);
    bif.basla = 1'b1;
    bif.sayi  = 64'd1000;
    @(negedge clk);
    bif.basla = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_bcd", bif.bcd, 80'h0);
    chk("midrst_flags", 80'({bif.isaret, bif.mesgul, bif.hazir}), 80'(0));
    last_bcd = '0;
    last_sgn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    chk("after_rst_bcd", bif.bcd, 80'h0);
    convert(64'd7);
    wait_idle();
    convert(64'hFFFF_FFFF_FFFF_FFFF - 64'd1);
    wait_idle();

    for (int k = 0; k < 12; k++) begin
      convert(rnd64());
      wait_idle();
    end

    hold_run(4);
    wait_idle();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending results expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_cevirici.md
# bcd_cevirici

- Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") for the calculator datapath.
- Sits directly downstream of the 32×32 multiplier and takes its 64-bit product.
- Produces 20 packed BCD digits for the display driver.
- Converts one operand per request, one bit per clock, with a start/busy/done handshake.

## Interface
Parameters:
- GENISLIK, 64, binary input width; fixed at 64 for this release.
- BASAMAK, 20, number of BCD output digits (ceil(64·log10 2) = 20).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- basla  input  1  start request; sampled on rising clk edges.
- sayi  input  64  binary operand; captured on the accepting edge only.
- bcd  output  80  packed result, digit 0 in [3:0], digit 19 in [79:76]; holds the last completed result.
- isaret  output  1  sign of the last result; only meaningful with BCD_ISARET_EN, otherwise constant 0.
- mesgul  output  1  conversion in progress.
- hazir  output  1  one-cycle pulse when bcd/isaret update.

## Operation
- States:
  - BOS: idle.
  - CEVIR: 64 iterations.
  - BITTI: completion cycle.
- Acceptance:
  - basla is accepted on any edge where state is BOS or BITTI (mesgul=0).
  - basla is ignored in CEVIR; no queuing.
- On accept:
  - Load internal 144-bit register as {80'b0, operand}.
  - Counter = 0.
  - State goes to CEVIR.
- Each CEVIR edge:
  - Every BCD nibble ≥5 gets +3 (combinational, all nibbles in parallel).
  - Then the whole register shifts left 1.
  - Counter increments.
- Leaving CEVIR:
  - On the edge where counter = 63 (the 64th shift), copy the upper 80 bits to bcd and set hazir=1.
  - State goes to BITTI.
- In BITTI:
  - hazir=1 for exactly this cycle.
  - Next edge: state goes to CEVIR if basla=1 (new accept), else BOS.
  - hazir returns to 0 on that edge.
- Output stability:
  - bcd and isaret are separate output registers, never disturbed mid-conversion.
  - They change only on a completion edge or on reset.
- Nibbles never exceed 9 in bcd. Max input 18446744073709551615 fills all 20 digits exactly, with no overflow.

## Timing
- Reset (asynchronous, immediate): bcd=0, isaret=0, mesgul=0, hazir=0, state BOS, counter=0, internal register 0.
- Latency: basla accepted at edge E → bcd valid and hazir=1 after edge E+64; hazir falls at E+65.
- mesgul: 1 after edge E through edge E+64; 0 in BITTI.
- Throughput: back-to-back accept possible at edge E+65 (from BITTI), i.e. one result per 65 cycles.
- sayi may change freely after the accepting edge.
- rst asserted mid-conversion: in-flight conversion abandoned, no hazir pulse. After release, first basla starts cleanly.
- basla held continuously: converts repeatedly, one accept per 65 cycles.

## Configuration
- Macro: BCD_ISARET_EN.
- Defined:
  - sayi is treated as two's complement.
  - On accept, sayi[63] is latched as the pending sign.
  - The magnitude (−sayi when negative, as unsigned 64-bit) is loaded; −2^63 gives 9223372036854775808.
  - isaret updates together with bcd on completion.
- Undefined:
  - sayi is unsigned, no negation logic is built, and isaret is tied to 0.
- Latency is identical in both builds.

## Test plan
- Reset, then sayi=0, basla 1 cycle → hazir pulses exactly 64 edges after accept; bcd=80'h0; mesgul high 64 cycles.
- sayi=255 → bcd=80'h…0255 (digits 5,5,2, rest 0); isaret=0.
- sayi=64'hFFFF_FFFF_FFFF_FFFF (unsigned build) → bcd=80'h18446744073709551615.
- sayi=12345, then basla re-pulsed at cycles 10 and 40 with sayi=99 → both ignored. Result 12345 at cycle 64; bcd holds previous value until then.
- Start conversion of 1000, assert rst at cycle 30 → all outputs 0 immediately, no hazir. Then convert 7 → bcd=…07 after 64 cycles.
- BCD_ISARET_EN build:
  - sayi=−1 → isaret=1, bcd=…01.
  - sayi=64'h8000_0000_0000_0000 → isaret=1, bcd=9223372036854775808.
  - basla held high → back-to-back results every 65 cycles.
